cv32e41p_instr_fetch_queue: RTL
===============================

// Module: cv32e41p_instr_fetch_queue
// PURPOSE
//  Fetch-side producer for the IF stage. It issues OBI instruction requests,
//  buffers the returned words in a small FIFO, and presents them on a
//  valid/ready handshake to the aligner. On a branch or hardware-loop jump it
//  flushes the FIFO and discards in-flight responses. It sits between the
//  instruction memory port and the IF stage; busy_o feeds if_busy_o.
// PARAMETERS
//  DEPTH            2  FIFO entries (32-bit words); power of 2, >=2
//  MAX_OUTSTANDING  2  max granted-but-not-returned OBI transactions, 1..DEPTH
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   reset, synchronous, active-low
//  req_i           in   1   fetch enable; 0 = issue no new requests
//  branch_i        in   1   redirect; flush and refetch from branch_addr_i
//  branch_addr_i   in   32  redirect target, bit0 = 0
//  hwlp_jump_i     in   1   hardware-loop redirect to hwlp_target_i
//  hwlp_target_i   in   32  hardware-loop target
//  fetch_ready_i   in   1   consumer accepts head word
//  fetch_valid_o   out  1   head word valid
//  fetch_rdata_o   out  32  head word
//  fetch_err_o     out  1   head word carried a bus error (see CONFIGURATION)
//  instr_req_o     out  1   OBI request
//  instr_addr_o    out  32  OBI address, [1:0] = 2'b00
//  instr_gnt_i     in   1   OBI grant
//  instr_rvalid_i  in   1   OBI response valid
//  instr_rdata_i   in   32  OBI response data
//  instr_err_i     in   1   OBI response error
//  busy_o          out  1   outstanding != 0 or instr_req_o
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): all outputs 0; FIFO empty; outstanding=0;
//    discard=0; FSM=IDLE; fetch address = 0. Reset mid-transaction drops all
//    state. Responses to pre-reset grants are not tracked.
//  - Credit: a new request is allowed when req_i && outstanding<MAX_OUTSTANDING
//    && (fifo_count+outstanding)<DEPTH. Every returned word therefore has a slot.
//  - FSM states:
//    IDLE: instr_req_o=credit. gnt -> addr+=4, stay IDLE. No gnt -> REQ_PEND.
//    REQ_PEND: instr_req_o=1; addr and req held stable until gnt (strict OBI).
//      Redirect -> store target, go to BR_WAIT. gnt -> IDLE.
//    BR_WAIT: instr_req_o=1 at the old addr until gnt. The response to that
//      request is marked discard. Then addr=stored target, go to IDLE.
//  - Redirect from IDLE or a granted cycle: addr={target[31:2],2'b00} next cycle.
//    FIFO is cleared. discard = outstanding_q + gnt_this_cycle - rvalid_this_cycle.
//    rvalid in the redirect cycle is dropped.
//  - branch_i and hwlp_jump_i in the same cycle: branch_i wins.
//  - Response: instr_rvalid_i && discard!=0 -> discard-- and data dropped.
//    Otherwise the word is pushed, or falls through when the FIFO is empty.
//  - outstanding_q: +1 on gnt, -1 on rvalid, both in one cycle -> unchanged.
//  - fetch_valid_o = !branch_i && !hwlp_jump_i &&
//    (fifo_count!=0 || (rvalid && discard==0)). Zero-latency fall-through.
//  - Pop on fetch_valid_o && fetch_ready_i. Push and pop in the same cycle
//    keep the count unchanged. A full FIFO cannot receive a push (credit rule).
//  - FIFO pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).
//  - rvalid while outstanding==0 is a protocol violation: ignored, and asserted.
// CONFIGURATION
//  CV32E41P_FETCH_ERR_EN defined: instr_err_i is stored per FIFO entry and
//    driven on fetch_err_o with its word. The fall-through path carries it too.
//  Not defined: instr_err_i is ignored and fetch_err_o is tied to 0.
// TESTING
//  T1 reset, req_i=1, gnt=1 and rvalid 1 cycle later -> addrs 0x0,0x4,0x8.
//     fetch_valid_o rises the same cycle as the first rvalid.
//  T2 fetch_ready_i=0, DEPTH=2 -> after 2 words, instr_req_o=0.
//     Holds 2 entries and never overflows.
//  T3 gnt stall at 0x8, branch_i to 0x100 -> 0x8 held until gnt.
//     Its response is dropped, next addr 0x100, first data from 0x100.
//  T4 2 outstanding, branch to 0x40 -> next 2 rvalids discarded.
//     fetch_valid_o stays 0 until the 0x40 word returns.
//  T5 branch_i and hwlp_jump_i together (0x200 vs 0x300) -> next addr 0x200.
//  T6 FETCH_ERR_EN: instr_err_i=1 on word 2 -> fetch_err_o=1 with word 2 only.
//     Without the macro fetch_err_o stays 0.

Source files
------------

// File: rtl/cv32e41p_instr_fetch_queue.sv
// cv32e41p_instr_fetch_queue
//   IF-stage fetch producer: issues OBI instruction requests, buffers the returned
//   words in a small FIFO and hands them to the aligner over valid/ready. Branch and
//   hardware-loop redirects flush the FIFO and discard in-flight responses.
//   Optional feature macro: CV32E41P_FETCH_ERR_EN (carry instr_err_i per word onto
//   fetch_err_o). When undefined, fetch_err_o is tied to 0.
module cv32e41p_instr_fetch_queue #(
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_jump_i,
  input  logic [31:0] hwlp_target_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StReqPend, StBrWait} state_e;

  state_e            r_state, w_state_next;
  logic [31:0]       r_addr, w_addr_next;
  logic [31:0]       r_target, w_target_next;
  logic [OutW-1:0]   r_outstanding, w_outstanding_next;
  logic [OutW-1:0]   r_discard, w_discard_next;

  logic [31:0]       r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;

  logic        w_redirect;
  logic [31:0] w_redirect_addr;
  logic        w_credit;
  logic        w_req;
  logic        w_gnt;
  logic        w_rvalid;
  logic        w_accept;
  logic        w_fifo_empty;
  logic        w_valid;
  logic        w_pop;
  logic        w_pop_fifo;
  logic        w_push;
  logic        w_brw_gnt;
  logic        w_discard_dec;

  // Redirect decode; branch has priority over the hardware-loop jump.
  always_comb begin
    w_redirect      = branch_i || hwlp_jump_i;
    w_redirect_addr = branch_i ? {branch_addr_i[31:2], 2'b00} : {hwlp_target_i[31:2], 2'b00};
  end

  // Request credit: every granted word is guaranteed a FIFO slot on return.
  always_comb begin
    w_credit = req_i && (32'(r_outstanding) < MAX_OUTSTANDING) &&
               ((32'(r_count) + 32'(r_outstanding)) < DEPTH);
  end

  // Request FSM: next state, next fetch address and request output.
  always_comb begin
    w_state_next  = r_state;
    w_addr_next   = r_addr;
    w_target_next = r_target;
    w_req         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req = w_credit;
        if (w_redirect) begin
          if (w_credit && !instr_gnt_i) begin
            // Request already on the bus must stay stable; finish it, then jump.
            w_target_next = w_redirect_addr;
            w_state_next  = StBrWait;
          end else begin
            w_addr_next = w_redirect_addr;
          end
        end else if (w_credit) begin
          if (instr_gnt_i) begin
            w_addr_next = r_addr + 32'd4;
          end else begin
            w_state_next = StReqPend;
          end
        end
      end
      StReqPend: begin
        w_req = 1'b1;
        if (instr_gnt_i) begin
          w_state_next = StIdle;
          w_addr_next  = w_redirect ? w_redirect_addr : (r_addr + 32'd4);
        end else if (w_redirect) begin
          w_target_next = w_redirect_addr;
          w_state_next  = StBrWait;
        end
      end
      StBrWait: begin
        w_req = 1'b1;
        if (w_redirect) begin
          w_target_next = w_redirect_addr;
        end
        if (instr_gnt_i) begin
          w_state_next = StIdle;
          w_addr_next  = w_redirect ? w_redirect_addr : r_target;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Handshake qualification and FIFO push/pop decisions.
  always_comb begin
    w_gnt        = w_req && instr_gnt_i;
    // An rvalid with nothing outstanding is a protocol violation and is ignored.
    w_rvalid     = instr_rvalid_i && (r_outstanding != '0);
    w_accept     = w_rvalid && !w_redirect && (r_discard == '0);
    w_fifo_empty = (r_count == '0);
    w_valid      = rst_n && !w_redirect && (!w_fifo_empty || w_accept);
    w_pop        = w_valid && fetch_ready_i;
    w_pop_fifo   = w_pop && !w_fifo_empty;
    // Word falls straight through when the FIFO is empty and the consumer takes it.
    w_push       = w_accept && !(w_fifo_empty && w_pop);
  end

  // Outstanding-transaction and discard counters.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_gnt && !w_rvalid) begin
      w_outstanding_next = r_outstanding + OutW'(1);
    end else if (!w_gnt && w_rvalid) begin
      w_outstanding_next = r_outstanding - OutW'(1);
    end

    w_brw_gnt      = (r_state == StBrWait) && w_gnt;
    w_discard_dec  = w_rvalid && (r_discard != '0);
    w_discard_next = r_discard;
    if (w_redirect) begin
      // Everything still in flight after this cycle belongs to the old stream.
      w_discard_next = w_outstanding_next;
    end else if (w_brw_gnt && !w_discard_dec) begin
      w_discard_next = r_discard + OutW'(1);
    end else if (!w_brw_gnt && w_discard_dec) begin
      w_discard_next = r_discard - OutW'(1);
    end
  end

  // FSM, address and counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_addr        <= 32'h0;
      r_target      <= 32'h0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_target      <= w_target_next;
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop_fifo) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop_fifo) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop_fifo) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // FIFO data storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= instr_rdata_i;
    end
  end

`ifdef CV32E41P_FETCH_ERR_EN
  logic r_err_mem [DEPTH];

  // Per-entry bus-error flag travelling alongside each buffered word.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_err_mem[r_wptr] <= instr_err_i;
    end
  end

  // Error output follows the same head/fall-through selection as the data.
  always_comb begin
    fetch_err_o = w_valid && (w_fifo_empty ? instr_err_i : r_err_mem[r_rptr]);
  end
`else
  logic w_unused_err;

  // Bus error is not propagated in this build.
  always_comb begin
    w_unused_err = instr_err_i;
    fetch_err_o  = 1'b0;
  end
`endif

  // Output drive; everything reads as zero while reset is asserted.
  always_comb begin
    fetch_valid_o = w_valid;
    fetch_rdata_o = rst_n ? (w_fifo_empty ? instr_rdata_i : r_mem[r_rptr]) : 32'h0;
    instr_req_o   = rst_n && w_req;
    instr_addr_o  = rst_n ? r_addr : 32'h0;
    busy_o        = rst_n && ((r_outstanding != '0) || w_req);
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && (r_outstanding == '0)));

endmodule
